// File: rtl/expansion_decoder.sv
`default_nettype none
// ============================================================================
// Module      : expansion_decoder
// Description : Inverts the DES E expansion. Collects eight 6-bit groups of a
//               48-bit expanded word, rebuilds the 32-bit half-block from the
//               centre bits and flags any disagreement in the duplicated edge
//               bits. Keeps a saturating count of erroneous words delivered.
// Revision    : 1.0 - initial release
// ============================================================================
module expansion_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:1]  in_grp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:1] out_word,
    output logic        out_err,
    output logic [8:1]  err_cnt
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    localparam logic [2:0] LAST_GROUP  = 3'd7;
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    // Groups 1..7 are buffered; group 8 is consumed straight from in_grp.
    logic [6:0][6:1] grp_q, grp_d;
    logic [32:1]     word_q, word_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [7:0][6:1] w_full;
    logic [32:1]     w_word;
    logic            w_err;

    assign in_ready  = (state_q == ST_COLLECT);
    assign out_valid = valid_q;
    assign out_word  = word_q;
    assign out_err   = err_q;
    assign err_cnt   = err_cnt_q;

    // Decode the complete 48-bit word (buffered groups plus the final group).
    always_comb begin
        w_full = {in_grp, grp_q};
        w_word = '0;
        w_err  = 1'b0;
        // Centre bits: group k bits [5:2] land on word bits [4k:4k-3].
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                w_word[4*k + 1 + i] = w_full[k][2 + i];
            end
        end
        // Edge bits duplicate a neighbour's centre bit; wrap at both ends.
        for (int k = 0; k < 8; k++) begin
            w_err = w_err | (w_full[k][1] ^ w_word[(k == 0) ? 32 : 4*k]);
            w_err = w_err | (w_full[k][6] ^ w_word[(k == 7) ? 1 : 4*k + 5]);
        end
    end

    // Next-state logic: collection, hold/handshake, flush and error counting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grp_d     = grp_q;
        word_d    = word_q;
        err_d     = err_q;
        valid_d   = valid_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_COLLECT: begin
                if (flush) begin
                    // Flush wins over a simultaneous group; that group is dropped.
                    cnt_d = '0;
                    grp_d = '0;
                end else if (in_valid) begin
                    if (cnt_q == LAST_GROUP) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        grp_d   = '0;
                        word_d  = w_word;
                        err_d   = w_err;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        for (int k = 0; k < 7; k++) begin
                            if (cnt_q == 3'(k)) begin
                                grp_d[k] = in_grp;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                // Flush and in_valid are ignored here; only the handshake matters.
                if (out_ready) begin
                    state_d = ST_COLLECT;
                    valid_d = 1'b0;
                    if (err_q && (err_cnt_q != ERR_CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            grp_q     <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grp_q     <= grp_d;
            word_q    <= word_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_expansion_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_expansion_decoder
// Description : Directed self-checking bench for expansion_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_expansion_decoder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:1]  in_grp;
    logic        out_valid;
    logic        out_ready;
    logic [32:1] out_word;
    logic        out_err;
    logic [8:1]  err_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    expansion_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_grp    (in_grp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference DES E expansion: group k (0-based) bit j is right[4k+j-1], wrapping 0->32, 33->1.
    function automatic logic [7:0][6:1] expand(input logic [32:1] r);
        logic [7:0][6:1] g;
        int n;
        g = '0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 1; j <= 6; j++) begin
                n = 4*k + j - 1;
                if (n == 0)  n = 32;
                if (n == 33) n = 1;
                g[k][j] = r[n];
            end
        end
        return g;
    endfunction

    task automatic send_grp(input logic [6:1] g);
        @(negedge clk);
        in_valid = 1'b1;
        in_grp   = g;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_grp   = '0;
    endtask

    // Sends a full word; out_valid must stay low until the last group lands.
    task automatic send_word(input logic [7:0][6:1] g);
        for (int k = 0; k < 7; k++) send_grp(g[k]);
        check_eq("no_early_valid", 32'(out_valid), 32'd0);
        send_grp(g[7]);
        check_eq("valid_after_g8", 32'(out_valid), 32'd1);
    endtask

    // Handshake the held word on the next edge.
    task automatic finish_word();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0][6:1] g;
        logic [32:1]     pat;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_grp    = '0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check_eq("rst_valid",   32'(out_valid), 32'd0);
        check_eq("rst_word",    32'(out_word),  32'd0);
        check_eq("rst_err",     32'(out_err),   32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // ---------------- all ones, out_ready held high ----------------
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) g[k] = 6'b111111;
        send_word(g);
        check_eq("ones_word", 32'(out_word), 32'hFFFF_FFFF);
        check_eq("ones_err",  32'(out_err),  32'd0);
        check_eq("ones_in_ready_hold", 32'(in_ready), 32'd0);
        finish_word();
        check_eq("ones_valid_after_hs", 32'(out_valid), 32'd0);
        check_eq("ones_in_ready_after", 32'(in_ready),  32'd1);
        check_eq("ones_err_cnt",        32'(err_cnt),   32'd0);

        // ---------------- only right[1] set, consistent edges ----------------
        g = '0;
        g[0] = 6'b000010;
        g[7] = 6'b100000;
        send_word(g);
        check_eq("r1_word", 32'(out_word), 32'h0000_0001);
        check_eq("r1_err",  32'(out_err),  32'd0);
        finish_word();
        check_eq("r1_err_cnt", 32'(err_cnt), 32'd0);

        // ---------------- general patterns via reference expansion ----------------
        pat = 32'hA5C3_1E97;
        send_word(expand(pat));
        check_eq("patA_word", 32'(out_word), 32'hA5C3_1E97);
        check_eq("patA_err",  32'(out_err),  32'd0);
        finish_word();
        pat = 32'h1234_5678;
        send_word(expand(pat));
        check_eq("patB_word", 32'(out_word), 32'h1234_5678);
        check_eq("patB_err",  32'(out_err),  32'd0);
        finish_word();

        // ---------------- right[1] with group 8 edge bit missing ----------------
        g = '0;
        g[0] = 6'b000010;
        send_word(g);
        check_eq("e1_word", 32'(out_word), 32'h0000_0001);
        check_eq("e1_err",  32'(out_err),  32'd1);
        finish_word();
        check_eq("e1_err_cnt", 32'(err_cnt), 32'd1);
        for (int w = 2; w <= 255; w++) begin
            send_word(g);
            finish_word();
        end
        check_eq("e255_err_cnt", 32'(err_cnt), 32'hFF);
        send_word(g);
        finish_word();
        check_eq("e256_err_cnt_sat", 32'(err_cnt), 32'hFF);

        // ---------------- wrap edge: group 1 bit 1 disagrees with right[32] ----------------
        g = '0;
        g[0] = 6'b000001;
        send_word(g);
        check_eq("wrap_word", 32'(out_word), 32'd0);
        check_eq("wrap_err",  32'(out_err),  32'd1);
        finish_word();
        check_eq("wrap_err_cnt_sat", 32'(err_cnt), 32'hFF);

        // ---------------- back-pressure with in_valid held high ----------------
        pat = 32'hDEAD_BEEF;
        send_word(expand(pat));
        @(negedge clk);
        in_valid = 1'b1;
        in_grp   = 6'b101010;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid",    32'(out_valid), 32'd1);
            check_eq("bp_word",     32'(out_word),  32'hDEAD_BEEF);
            check_eq("bp_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_grp    = '0;
        out_ready = 1'b0;
        check_eq("bp_valid_after_hs", 32'(out_valid), 32'd0);
        check_eq("bp_in_ready_after", 32'(in_ready),  32'd1);
        pat = 32'h0F0F_3C3C;
        send_word(expand(pat));
        check_eq("bp_next_word", 32'(out_word), 32'h0F0F_3C3C);
        check_eq("bp_next_err",  32'(out_err),  32'd0);

        // ---------------- flush while holding has no effect ----------------
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("hold_flush_valid", 32'(out_valid), 32'd1);
        check_eq("hold_flush_word",  32'(out_word),  32'h0F0F_3C3C);
        finish_word();

        // ---------------- flush mid-collection alongside in_valid ----------------
        send_grp(6'b111111);
        send_grp(6'b110011);
        send_grp(6'b101101);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_grp   = 6'b111111;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        pat = 32'h8421_C3A5;
        send_word(expand(pat));
        check_eq("flush_word", 32'(out_word), 32'h8421_C3A5);
        check_eq("flush_err",  32'(out_err),  32'd0);
        finish_word();

        // ---------------- asynchronous reset mid-collection ----------------
        pat = 32'h5555_AAAA;
        g = expand(pat);
        for (int k = 0; k < 5; k++) send_grp(g[k]);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid",   32'(out_valid), 32'd0);
        check_eq("arst_word",    32'(out_word),  32'd0);
        check_eq("arst_err",     32'(out_err),   32'd0);
        check_eq("arst_err_cnt", 32'(err_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        pat = 32'h3C96_F00D;
        send_word(expand(pat));
        check_eq("arst_next_word", 32'(out_word), 32'h3C96_F00D);
        check_eq("arst_next_err",  32'(out_err),  32'd0);
        finish_word();
        check_eq("arst_next_err_cnt", 32'(err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/expansion_decoder.md
EXPANSION_DECODER -- requirements
Module: expansion_decoder

Interface
REQ-001 The block SHALL have these ports, clock and reset first; all outputs are registered except in_ready:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of the word in progress.
- in_valid  in  1  in_grp carries a valid 6-bit group.
- in_ready  out  1  block accepts a group this cycle.
- in_grp  in  [6:1]  one 6-bit group of the 48-bit expanded word.
- out_valid  out  1  out_word and out_err are valid.
- out_ready  in  1  consumer accepts the word.
- out_word  out  [32:1]  reconstructed 32-bit half-block.
- out_err  out  1  duplicate-bit mismatch detected in this word.
- err_cnt  out  [8:1]  saturating count of words delivered with out_err=1.
REQ-002 Reset SHALL be one clock domain (clk) with rst_n asynchronous, active-low.

Function
REQ-003 The block SHALL invert the DES E expansion: 8 groups arrive in order k=1..8, and in_grp[j] of group k is expanded bit 6(k-1)+j.
REQ-004 Group k, position j SHALL correspond to source bit right[n], where n = 4(k-1)+j-1, mapping n=0 to 32 and n=33 to 1.
REQ-005 The state machine SHALL have two states:
- COLLECT: in_ready=1, 3-bit group counter.
- HOLD: in_ready=0, out_valid=1.
REQ-006 A group SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; the counter then increments and the group is stored.
REQ-007 On acceptance of group 8, the block SHALL enter HOLD on the next edge, with out_word, out_err and out_valid=1 all registered on that same edge (latency 1 cycle).
REQ-008 out_word SHALL be built from the centre bits: group k in_grp[5:2] maps to out_word[4k:4k-3], with in_grp[2] to out_word[4k-3].
REQ-009 out_err SHALL be the OR of 16 edge checks:
- group k in_grp[1] against out_word[4k-4] (k=1 uses out_word[32]).
- group k in_grp[6] against out_word[4k+1] (k=8 uses out_word[1]).
REQ-010 The wrap-around edge bits of group 1 SHALL be retained until group 8 has been accepted.
REQ-011 In HOLD, out_word, out_err and out_valid SHALL stay stable until out_valid=1 and out_ready=1; the block then returns to COLLECT with counter 0 on the next edge.
REQ-012 When out_valid=1 and out_ready=1 on a word with out_err=1, err_cnt SHALL increment by 1 and saturate at 8'hFF.
REQ-013 In HOLD, in_valid SHALL be ignored; no back-to-back overlap of words is permitted.
REQ-014 flush=1 in COLLECT SHALL clear the counter and stored groups next edge; flush has priority over a simultaneous in_valid, and that group is discarded.
REQ-015 flush=1 in HOLD SHALL have no effect; the held word is still delivered.
REQ-016 out_word and out_err SHALL be driven only from fully collected words and never expose partial data.

Reset
REQ-017 While rst_n=0, the block SHALL hold state COLLECT, counter 0, out_valid 0, out_word 0, out_err 0, err_cnt 0 and all stored groups 0.
REQ-018 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-019 Reset asserted mid-collection or in HOLD SHALL abandon the word with no output handshake.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- 8 groups of 6'b111111, out_ready=1 -> out_valid 1 cycle after group 8; out_word all ones; out_err 0.
- Word with only right[1]=1: group1 in_grp[2]=1, group8 in_grp[6]=1, rest 0 -> out_word[1]=1 only; out_err 0; err_cnt 0.
- As above but group8 in_grp[6]=0 -> out_word[1]=1, out_err=1, err_cnt 1 after handshake; 255 such words, then one more -> err_cnt stays 8'hFF.
- out_ready low for 5 cycles after completion while in_valid=1 -> out_valid and out_word stable, in_ready 0, no group consumed; handshake on cycle 6, in_ready 1 on next cycle.
- 3 groups, then flush together with in_valid, then 8 fresh groups -> output reflects only fresh groups; counter restarted.
- rst_n pulsed low after 5 groups (asynchronous, mid-cycle) -> outputs 0 immediately; next 8 groups form a clean word.
